// File: rtl/bnn_sequencer.sv
// rtl/bnn_sequencer.sv - BNN pipeline scheduler: image load, layer sequencing, watchdog, result hold.
module bnn_sequencer #(
    parameter int PIX_BITS = 784,
    parameter int IN_W     = 8,
    parameter int TIMEOUT  = 4095,
    parameter int CLASS_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     in_data,
    output logic                in_ready,
    input  logic                l1_done,
    input  logic                l2_done,
    input  logic                l3_done,
    input  logic [CLASS_W-1:0]  l3_class,
    output logic [2:0]          state,
    output logic [0:PIX_BITS-1] pixels,
    output logic                layer_clr,
    output logic                busy,
    output logic                result_valid,
    output logic [CLASS_W-1:0]  result_class,
    input  logic                result_ack,
    output logic                error
);

    localparam int BEATS = PIX_BITS / IN_W;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int PX_W  = $clog2(PIX_BITS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_LOAD    = 3'b001,
        S_LAYER_1 = 3'b010,
        S_LAYER_2 = 3'b011,
        S_LAYER_3 = 3'b100,
        S_RESULT  = 3'b101,
        S_ERROR   = 3'b110
    } state_e;

    state_e               state_q, state_d;
    logic [0:PIX_BITS-1]  pixels_q, pixels_d;
    logic [BC_W-1:0]      beat_q, beat_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic [CLASS_W-1:0]   rclass_q, rclass_d;
    logic                 clr_q, clr_d;
    logic                 layer_done;
    state_e               layer_next;
    logic [PX_W-1:0]      base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pixels_q <= '0;
            beat_q   <= '0;
            wdog_q   <= '0;
            rclass_q <= '0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pixels_q <= pixels_d;
            beat_q   <= beat_d;
            wdog_q   <= wdog_d;
            rclass_q <= rclass_d;
            clr_q    <= clr_d;
        end
    end

    // Only the running stage's done input is looked at.
    always_comb begin
        layer_done = 1'b0;
        layer_next = S_ERROR;
        case (state_q)
            S_LAYER_1: begin layer_done = l1_done; layer_next = S_LAYER_2; end
            S_LAYER_2: begin layer_done = l2_done; layer_next = S_LAYER_3; end
            S_LAYER_3: begin layer_done = l3_done; layer_next = S_RESULT;  end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pixels_d = pixels_q;
        beat_d   = beat_q;
        wdog_d   = '0;
        rclass_d = rclass_q;
        clr_d    = 1'b0;
        base     = PX_W'(beat_q) * PX_W'(IN_W);
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    beat_d  = '0;
                    clr_d   = 1'b1;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    // Ascending vector: in_data MSB lands on the lowest pixel index of the beat.
                    pixels_d[base +: IN_W] = in_data;
                    if (beat_q == BC_W'(BEATS - 1)) begin
                        state_d = S_LAYER_1;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BC_W'(1);
                    end
                end
            end
            S_LAYER_1, S_LAYER_2, S_LAYER_3: begin
                if (layer_done) begin
                    state_d = layer_next;
                    if (state_q == S_LAYER_3) rclass_d = l3_class;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                end else if (wdog_q != WD_W'(TIMEOUT)) begin
                    wdog_d = wdog_q + WD_W'(1);
                end else begin
                    wdog_d = wdog_q;
                end
            end
            S_RESULT: begin
                if (result_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state        = state_q;
    assign pixels       = pixels_q;
    assign layer_clr    = clr_q;
    assign result_class = rclass_q;
    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD) || (state_q == S_LAYER_1) ||
                          (state_q == S_LAYER_2) || (state_q == S_LAYER_3);
    assign result_valid = (state_q == S_RESULT);
    assign error        = (state_q == S_ERROR);

endmodule

// File: tb/tb_bnn_sequencer.sv
// tb/tb_bnn_sequencer.sv - scoreboard bench for bnn_sequencer.
module tb_bnn_sequencer;

    localparam int PIX   = 784;
    localparam int BEATS = 98;
    localparam int TO    = 256;

    logic           clk = 1'b0;
    logic           rst, start, in_valid, in_ready;
    logic [7:0]     in_data;
    logic           l1_done, l2_done, l3_done;
    logic [3:0]     l3_class;
    logic [2:0]     state;
    logic [0:PIX-1] pixels;
    logic           layer_clr, busy, result_valid, result_ack, error;
    logic [3:0]     result_class;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [3:0] cls_q[$];

    bnn_sequencer #(.PIX_BITS(PIX), .IN_W(8), .TIMEOUT(TO), .CLASS_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done),
        .l3_class(l3_class), .state(state), .pixels(pixels), .layer_clr(layer_clr),
        .busy(busy), .result_valid(result_valid), .result_class(result_class),
        .result_ack(result_ack), .error(error)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0; l3_class = '0; result_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        cls_q.delete();
    endtask

    // Start is raised for one edge, then beats streamed with in_valid low every 3rd cycle.
    task automatic do_load(input logic [7:0] base_val, input bit vary, input int nbeats,
                           input bit pulse_start, output int clr_cnt);
        int k = 0;
        int cyc = 0;
        clr_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        while (k < nbeats && cyc < 1000) begin
            @(negedge clk);
            start = pulse_start && (cyc == 10);
            if (layer_clr) clr_cnt++;
            in_valid = (cyc % 3 != 2);
            in_data = vary ? base_val + 8'(k) : base_val;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                k++;
            end
            cyc++;
        end
        checks++;
        if (k != nbeats) begin
            failures++;
            $display("FAIL load_beats got=%0d exp=%0d", k, nbeats);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0; l3_class = '0; result_ack = 1'b0;
        #1;
        checks++; if (state !== 3'b000) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (pixels !== '0) begin failures++; $display("FAIL rst_pixels got=nonzero exp=0"); end
        checks++; if ({in_ready, busy, result_valid, error, layer_clr} !== 5'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=00000", {in_ready, busy, result_valid, error, layer_clr});
        end
        checks++; if (result_class !== 4'd0) begin failures++; $display("FAIL rst_class got=%0d exp=0", result_class); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load();
        int clr;
        do_reset();
        do_load(8'hA5, 1'b0, BEATS, 1'b0, clr);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (clr != 1) begin failures++; $display("FAIL load_clr_cycles got=%0d exp=1", clr); end
        checks++; if (state !== 3'b010) begin failures++; $display("FAIL load_to_l1 got=%0d exp=2", state); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL load_ready_after got=%b exp=0", in_ready); end
        checks++; if (busy !== 1'b1 || layer_clr !== 1'b0) begin
            failures++; $display("FAIL load_busy_clr got=%b%b exp=10", busy, layer_clr);
        end
        for (int k = 0; k < BEATS; k++) begin
            logic [7:0] e, g;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            for (int j = 0; j < 8; j++) g[7-j] = pixels[k*8+j];
            checks++;
            if (g !== e) begin failures++; $display("FAIL load_pixels beat=%0d got=%h exp=%h", k, g, e); end
        end
    endtask

    task automatic test_full_run();
        int clr;
        int bad = 0;
        logic [3:0] e;
        do_reset();
        do_load(8'h3C, 1'b1, BEATS, 1'b0, clr);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (199) @(negedge clk);
        l1_done = 1'b1;
        @(negedge clk);
        l1_done = 1'b0;
        checks++; if (state !== 3'b011) begin failures++; $display("FAIL run_l2 got=%0d exp=3", state); end
        repeat (49) @(negedge clk);
        l2_done = 1'b1;
        @(negedge clk);
        l2_done = 1'b0;
        checks++; if (state !== 3'b100) begin failures++; $display("FAIL run_l3 got=%0d exp=4", state); end
        l3_class = 4'd7; l3_done = 1'b1; cls_q.push_back(4'd7);
        @(negedge clk);
        l3_done = 1'b0; l3_class = 4'd0;
        e = cls_q.pop_front();
        checks++; if (state !== 3'b101 || result_valid !== 1'b1) begin
            failures++; $display("FAIL run_result got=%0d/%b exp=5/1", state, result_valid);
        end
        checks++; if (result_class !== e) begin failures++; $display("FAIL run_class got=%0d exp=%0d", result_class, e); end
        repeat (10) begin
            @(negedge clk);
            if (result_valid !== 1'b1 || result_class !== e || state !== 3'b101) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL run_hold got=%0d exp=0 bad cycles", bad); end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        checks++; if (state !== 3'b000 || result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL run_ack got=%0d/%b/%b exp=0/0/0", state, result_valid, busy);
        end
        checks++; if (result_class !== e) begin failures++; $display("FAIL run_class_idle got=%0d exp=%0d", result_class, e); end
    endtask

    task automatic test_timeout();
        int clr;
        do_reset();
        do_load(8'h5A, 1'b0, BEATS, 1'b0, clr);
        @(negedge clk);
        in_valid = 1'b0;
        l1_done = 1'b1;
        @(negedge clk);
        l1_done = 1'b0;
        repeat (TO - 1) @(negedge clk);
        checks++; if (state !== 3'b011 || error !== 1'b0) begin
            failures++; $display("FAIL to_last_cycle got=%0d/%b exp=3/0", state, error);
        end
        @(negedge clk);
        checks++; if (state !== 3'b110 || error !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL to_error got=%0d/%b/%b exp=6/1/0", state, error, busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (state !== 3'b001 || error !== 1'b0 || layer_clr !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL to_restart got=%0d/%b/%b/%b exp=1/0/1/1", state, error, layer_clr, busy);
        end
    endtask

    task automatic test_done_boundary();
        int clr;
        logic [3:0] e;
        do_reset();
        do_load(8'h11, 1'b1, BEATS, 1'b0, clr);
        @(negedge clk);
        in_valid = 1'b0;
        l3_done = 1'b1; l2_done = 1'b1;
        repeat (TO - 1) @(negedge clk);
        checks++; if (state !== 3'b010) begin failures++; $display("FAIL bnd_other_done got=%0d exp=2", state); end
        l1_done = 1'b1;
        @(negedge clk);
        l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
        checks++; if (state !== 3'b011 || error !== 1'b0) begin
            failures++; $display("FAIL bnd_done_wins got=%0d/%b exp=3/0", state, error);
        end
        l2_done = 1'b1;
        @(negedge clk);
        l2_done = 1'b0;
        l3_class = 4'hC; l3_done = 1'b1; cls_q.push_back(4'hC);
        @(negedge clk);
        l3_done = 1'b0;
        e = cls_q.pop_front();
        checks++; if (state !== 3'b101 || result_class !== e) begin
            failures++; $display("FAIL bnd_result got=%0d/%0h exp=5/%0h", state, result_class, e);
        end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int clr;
        do_reset();
        do_load(8'h00, 1'b1, 50, 1'b0, clr);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (state !== 3'b001) begin failures++; $display("FAIL mid_in_load got=%0d exp=1", state); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state !== 3'b000 || in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_async got=%0d/%b/%b exp=0/0/0", state, in_ready, busy);
        end
        checks++; if (pixels !== '0) begin failures++; $display("FAIL mid_pixels got=nonzero exp=0"); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        do_load(8'h80, 1'b1, BEATS, 1'b0, clr);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (state !== 3'b010) begin failures++; $display("FAIL mid_reload got=%0d exp=2", state); end
        for (int k = 0; k < BEATS; k++) begin
            logic [7:0] e, g;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            for (int j = 0; j < 8; j++) g[7-j] = pixels[k*8+j];
            checks++;
            if (g !== e) begin failures++; $display("FAIL mid_pixels_reload beat=%0d got=%h exp=%h", k, g, e); end
        end
    endtask

    task automatic test_start_ignored();
        int clr;
        int bad = 0;
        logic [3:0] e;
        do_reset();
        do_load(8'h40, 1'b1, BEATS, 1'b1, clr);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        checks++; if (state !== 3'b010 || clr != 1) begin
            failures++; $display("FAIL ign_load got=%0d/%0d exp=2/1", state, clr);
        end
        for (int k = 0; k < BEATS; k++) begin
            logic [7:0] x, g;
            x = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            for (int j = 0; j < 8; j++) g[7-j] = pixels[k*8+j];
            checks++;
            if (g !== x) begin failures++; $display("FAIL ign_pixels beat=%0d got=%h exp=%h", k, g, x); end
        end
        l1_done = 1'b1;
        @(negedge clk);
        l1_done = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (state !== 3'b011) bad++;
        end
        start = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL ign_l2 got=%0d exp=0 bad cycles", bad); end
        l2_done = 1'b1;
        @(negedge clk);
        l2_done = 1'b0;
        l3_class = 4'd9; l3_done = 1'b1; cls_q.push_back(4'd9);
        @(negedge clk);
        l3_done = 1'b0; l3_class = 4'd2;
        e = cls_q.pop_front();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        checks++; if (state !== 3'b101 || result_class !== e || result_valid !== 1'b1) begin
            failures++; $display("FAIL ign_result got=%0d/%0d exp=5/%0d", state, result_class, e);
        end
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        @(negedge clk);
        checks++; if (state !== 3'b000) begin failures++; $display("FAIL ign_idle got=%0d exp=0", state); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_full_run();
        test_timeout();
        test_done_boundary();
        test_reset_mid();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
